// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div P/W sequencer.
// Optional feature macro: MULTDIV_TIMEOUT_EN (WAIT-state watchdog).
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam logic [2:0] EXC_NONE    = 3'd0;
  localparam logic [2:0] EXC_MULT    = 3'd1;
  localparam logic [2:0] EXC_DIV     = 3'd2;
  localparam logic [2:0] EXC_TIMEOUT = 3'd7;

  localparam int unsigned MAX_CYCLES_DEFAULT = 40;

  // Exception code reported alongside a unit result.
  function automatic logic [2:0] exc_code(input op_e op, input logic exc);
    if (!exc) return EXC_NONE;
    return (op == OP_MULT) ? EXC_MULT : EXC_DIV;
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Saturating WAIT-state cycle counter. Only compiled and used when
// MULTDIV_TIMEOUT_EN is defined.
`ifdef MULTDIV_TIMEOUT_EN
module multdiv_watchdog #(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Counter holds the number of WAIT cycles already spent; saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != SAT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expires during the MAX_CYCLES-th WAIT cycle so DONE follows directly.
  assign expired_o = enable_i && (count_q >= LIMIT);

endmodule
`endif

// File: rtl/multdiv_pw_sequencer.sv
// Sequencer for the multicycle mult/div unit feeding the P/W register.
// Detects MUL/DIV in X, stalls, pulses start, waits for md_ready and
// presents the result to P/W for exactly one cycle.
// Optional feature macro: MULTDIV_TIMEOUT_EN (forces DONE with
// EXC_TIMEOUT after MAX_CYCLES WAIT cycles without md_ready).
//
// Handshake: the unit's md_ready is a one-cycle valid pulse (no back-
// pressure) that is only honoured in WAIT; pw_enable_instr is a one-cycle
// valid to the P/W register, which always accepts.
module multdiv_pw_sequencer
  import multdiv_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              is_mult_x,
  input  logic              is_div_x,
  input  logic [DATA_W-1:0] instr_x,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_ready,
  input  logic              md_exception,
  output logic              ctrl_mult,
  output logic              ctrl_div,
  output logic              stall,
  output logic              busy,
  output logic              pw_enable_instr,
  output logic [DATA_W-1:0] pw_instr,
  output logic [DATA_W-1:0] pw_p,
  output logic              pw_r,
  output logic [2:0]        pw_e,
  output state_e            dbg_state_o
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              ctrl_mult_q, ctrl_mult_d;
  logic              ctrl_div_q, ctrl_div_d;
  logic              busy_q, busy_d;
  logic              pw_en_q, pw_en_d;
  logic [DATA_W-1:0] pw_instr_q, pw_instr_d;
  logic [DATA_W-1:0] pw_p_q, pw_p_d;
  logic              pw_r_q, pw_r_d;
  logic [2:0]        pw_e_q, pw_e_d;
  logic              stall_w;
  logic              timeout_w;

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (state_q == START),
    .enable_i (state_q == WAIT),
    .expired_o(timeout_w)
  );
`else
  logic unused_max_cycles;
  assign unused_max_cycles = (MAX_CYCLES != 0);
  assign timeout_w         = 1'b0;
`endif

  // Next-state, held-operand capture and next values of registered outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    instr_d    = instr_q;
    stall_w    = 1'b0;
    pw_p_d     = '0;
    pw_e_d     = EXC_NONE;
    pw_en_d    = 1'b0;
    pw_r_d     = 1'b0;
    pw_instr_d = '0;

    case (state_q)
      IDLE: begin
        if (is_mult_x || is_div_x) begin
          stall_w = 1'b1;
          instr_d = instr_x;
          op_d    = is_mult_x ? OP_MULT : OP_DIV;
          state_d = START;
        end
      end
      START: begin
        stall_w = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        stall_w = 1'b1;
        if (md_ready) begin
          state_d = DONE;
          pw_p_d  = md_result;
          pw_e_d  = exc_code(op_q, md_exception);
        end else if (timeout_w) begin
          state_d = DONE;
          pw_p_d  = '0;
          pw_e_d  = EXC_TIMEOUT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      pw_en_d    = 1'b1;
      pw_r_d     = 1'b1;
      pw_instr_d = instr_q;
    end

    ctrl_mult_d = (state_d == START) && (op_d == OP_MULT);
    ctrl_div_d  = (state_d == START) && (op_d == OP_DIV);
    busy_d      = (state_d != IDLE);
  end

  // State, held operands and registered outputs; synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_MULT;
      instr_q     <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      busy_q      <= 1'b0;
      pw_en_q     <= 1'b0;
      pw_instr_q  <= '0;
      pw_p_q      <= '0;
      pw_r_q      <= 1'b0;
      pw_e_q      <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      instr_q     <= instr_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      busy_q      <= busy_d;
      pw_en_q     <= pw_en_d;
      pw_instr_q  <= pw_instr_d;
      pw_p_q      <= pw_p_d;
      pw_r_q      <= pw_r_d;
      pw_e_q      <= pw_e_d;
    end
  end

  // Stall is combinational so a newly detected op freezes F/D/X at once.
  assign stall           = stall_w && !reset;
  assign ctrl_mult       = ctrl_mult_q;
  assign ctrl_div        = ctrl_div_q;
  assign busy            = busy_q;
  assign pw_enable_instr = pw_en_q;
  assign pw_instr        = pw_instr_q;
  assign pw_p            = pw_p_q;
  assign pw_r            = pw_r_q;
  assign pw_e            = pw_e_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_multdiv_pw_sequencer.sv
// Directed bench for multdiv_pw_sequencer: expected P/W transactions and
// start pulses go into queues as stimulus is issued; a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_multdiv_pw_sequencer;
  import multdiv_pkg::*;

  localparam int W = 69; // {pw_enable_instr, pw_instr, pw_p, pw_r, pw_e}

  logic        clock;
  logic        reset;
  logic        is_mult_x, is_div_x;
  logic [31:0] instr_x, md_result;
  logic        md_ready, md_exception;
  logic        ctrl_mult, ctrl_div, stall, busy, pw_enable_instr, pw_r;
  logic [31:0] pw_instr, pw_p;
  logic [2:0]  pw_e;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_ctrl_q[$];

  multdiv_pw_sequencer #(
    .DATA_W    (32),
    .MAX_CYCLES(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .is_mult_x      (is_mult_x),
    .is_div_x       (is_div_x),
    .instr_x        (instr_x),
    .md_result      (md_result),
    .md_ready       (md_ready),
    .md_exception   (md_exception),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .stall          (stall),
    .busy           (busy),
    .pw_enable_instr(pw_enable_instr),
    .pw_instr       (pw_instr),
    .pw_p           (pw_p),
    .pw_r           (pw_r),
    .pw_e           (pw_e),
    .dbg_state_o    (dbg_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver helpers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    is_mult_x    = 1'b0;
    is_div_x     = 1'b0;
    instr_x      = '0;
    md_result    = '0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
  endtask

  task automatic push_pw(input logic [31:0] ins, input logic [31:0] p, input logic [2:0] e);
    exp_q.push_back({1'b1, ins, p, 1'b1, e});
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [W-1:0] item;
    logic [1:0]   citem;
    if (pw_enable_instr === 1'b1 || pw_r === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pw: got instr %h p %h r %b e %0d expected no transaction",
                 pw_instr, pw_p, pw_r, pw_e);
      end else begin
        item = exp_q.pop_front();
        chk("pw_txn", {pw_enable_instr, pw_instr, pw_p, pw_r, pw_e}, item);
      end
    end
    if (ctrl_mult === 1'b1 || ctrl_div === 1'b1) begin
      if (exp_ctrl_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got mult %b div %b expected no pulse", ctrl_mult, ctrl_div);
      end else begin
        citem = exp_ctrl_q.pop_front();
        chk("start_pulse", W'({ctrl_mult, ctrl_div}), W'(citem));
      end
    end
  end

  // Stimulus
  initial begin
    int bad;
    idle_inputs();
    reset = 1'b1;

    // Reset state
    step();
    at_neg();
    chk("reset_stall", W'(stall), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_pw", {pw_enable_instr, pw_instr, pw_p, pw_r, pw_e}, '0);
    chk("reset_ctrl", W'({ctrl_mult, ctrl_div}), W'(0));
    step();
    reset = 1'b0;
    at_neg();
    chk("post_reset_idle", W'({dbg_state, busy, stall}), W'({IDLE, 2'b00}));
    step();
    at_neg();
    chk("no_start_after_reset", W'({ctrl_mult, ctrl_div}), W'(0));

    // MULT, ready after 4 cycles
    step();
    is_mult_x = 1'b1; instr_x = 32'h00A3_1020;
    exp_ctrl_q.push_back(2'b10);
    push_pw(32'h00A3_1020, 32'h0000_0042, EXC_NONE);
    at_neg();
    chk("mult_detect_stall", W'({stall, busy}), W'(2'b10));
    step();
    at_neg();
    chk("mult_start_state", W'({dbg_state, stall, busy}), W'({START, 2'b11}));
    for (int i = 0; i < 3; i++) begin
      step();
      at_neg();
      chk("mult_wait_stall", W'({dbg_state, stall}), W'({WAIT, 1'b1}));
    end
    step();
    md_ready = 1'b1; md_result = 32'h0000_0042;
    at_neg();
    chk("mult_ready_stall", W'(stall), W'(1));
    step();
    is_mult_x = 1'b0; instr_x = '0; md_ready = 1'b0; md_result = '0;
    at_neg();
    chk("mult_done_stall", W'({dbg_state, stall}), W'({DONE, 1'b0}));
    step();
    at_neg();
    chk("mult_after_done", W'({busy, pw_enable_instr, pw_p}), '0);

    // DIV by zero, earliest ready
    step();
    is_div_x = 1'b1; instr_x = 32'h0085_001A;
    exp_ctrl_q.push_back(2'b01);
    push_pw(32'h0085_001A, 32'hFFFF_FFFF, EXC_DIV);
    step();
    step();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    at_neg();
    chk("div_done_latency", W'({dbg_state, pw_enable_instr}), W'({DONE, 1'b1}));
    step();

    // Reset mid-operation with md_ready in the same cycle
    step();
    is_mult_x = 1'b1; instr_x = 32'h0000_0BAD;
    exp_ctrl_q.push_back(2'b10);
    step();
    step();
    at_neg();
    chk("rst_mid_in_wait", W'(dbg_state), W'(WAIT));
    step();
    reset = 1'b1; md_ready = 1'b1; md_result = 32'h1111_2222;
    at_neg();
    chk("rst_mid_stall_low", W'(stall), W'(0));
    step();
    reset = 1'b0; idle_inputs();
    at_neg();
    chk("rst_mid_idle", W'({dbg_state, stall, busy}), W'({IDLE, 2'b00}));
    chk("rst_mid_pw_clear", {pw_enable_instr, pw_instr, pw_p, pw_r, pw_e}, '0);
    for (int i = 0; i < 4; i++) step();

    // Both ops high, spurious ready in IDLE, START and DONE
    step();
    md_ready = 1'b1; md_result = 32'h5555_5555;
    step();
    md_ready = 1'b0;
    is_mult_x = 1'b1; is_div_x = 1'b1; instr_x = 32'h1234_5678;
    exp_ctrl_q.push_back(2'b10);
    push_pw(32'h1234_5678, 32'h0000_0006, EXC_NONE);
    step();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
      at_neg();
      chk("spurious_stay_wait", W'({dbg_state, pw_enable_instr}), W'({WAIT, 1'b0}));
    end
    step();
    md_ready = 1'b1; md_result = 32'h0000_0006;
    step();
    is_mult_x = 1'b0; is_div_x = 1'b0; instr_x = '0;
    md_result = 32'h7777_7777;
    at_neg();
    chk("both_done", W'(dbg_state), W'(DONE));
    step();
    md_ready = 1'b0; md_result = '0;
    at_neg();
    chk("spurious_done_ignored", W'({dbg_state, busy}), W'({IDLE, 1'b0}));
    step();

    // Back-to-back MULTs, is_mult_x held through DONE and next IDLE
    step();
    is_mult_x = 1'b1; instr_x = 32'h0000_A0A0;
    exp_ctrl_q.push_back(2'b10);
    push_pw(32'h0000_A0A0, 32'h0000_0011, EXC_NONE);
    step();
    step();
    md_ready = 1'b1; md_result = 32'h0000_0011;
    step();
    md_ready = 1'b0; md_result = '0;
    at_neg();
    chk("b2b_done_ignores_op", W'({dbg_state, stall, ctrl_mult}), W'({DONE, 2'b00}));
    step();
    instr_x = 32'h0000_B0B0;
    exp_ctrl_q.push_back(2'b10);
    push_pw(32'h0000_B0B0, 32'h0000_0022, EXC_NONE);
    at_neg();
    chk("b2b_idle_detect", W'({dbg_state, stall}), W'({IDLE, 1'b1}));
    step();
    at_neg();
    chk("b2b_second_start", W'({dbg_state, ctrl_mult}), W'({START, 1'b1}));
    step();
    md_ready = 1'b1; md_result = 32'h0000_0022;
    step();
    idle_inputs();
    step();
    step();

    // WAIT with no md_ready
    step();
    is_mult_x = 1'b1; instr_x = 32'h0000_C0DE;
    exp_ctrl_q.push_back(2'b10);
`ifdef MULTDIV_TIMEOUT_EN
    push_pw(32'h0000_C0DE, 32'h0000_0000, EXC_TIMEOUT);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      at_neg();
      chk("timeout_wait", W'({dbg_state, stall}), W'({WAIT, 1'b1}));
    end
    step();
    idle_inputs();
    at_neg();
    chk("timeout_done", W'({dbg_state, stall}), W'({DONE, 1'b0}));
    step();
`else
    push_pw(32'h0000_C0DE, 32'h0000_0099, EXC_NONE);
    step();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      at_neg();
      if (!(dbg_state == WAIT && stall === 1'b1)) bad++;
    end
    chk("no_timeout_hold_wait", W'(bad), W'(0));
    step();
    md_ready = 1'b1; md_result = 32'h0000_0099;
    step();
    idle_inputs();
    at_neg();
    chk("no_timeout_release", W'({dbg_state, stall}), W'({DONE, 1'b0}));
    step();
`endif

    for (int i = 0; i < 3; i++) step();
    chk("pw_queue_drained", W'(exp_q.size()), W'(0));
    chk("start_queue_drained", W'(exp_ctrl_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
